// File: rtl/alu_sequencer.sv
// alu_sequencer
// Arbitrates between two requesters (round-robin), then sequences one ALU
// operation: drives operand A and operand B onto a shared bus with separate
// load strobes, holds the opcode for EXEC_CYCLES cycles, captures the ALU
// result/carry and returns it on a valid/ready response channel tagged with
// the index of the served requester.
//
// Parameters
//   EXEC_CYCLES  cycles spent in EXEC before result capture (legal 1..15)
// Ports
//   clk                    rising-edge clock
//   reset                  synchronous active-low reset
//   req_valid[1:0]         per-requester request valid
//   req_ready[1:0]         per-requester accept strobe (one-hot, IDLE only)
//   req_a0/req_b0/req_op0  requester 0 operands and opcode
//   req_a1/req_b1/req_op1  requester 1 operands and opcode
//   reg_data               shared bus to both operand registers
//   load_a / load_b        load strobes for operand registers A / B
//   alu_op                 opcode presented to the ALU
//   alu_result/alu_carry   combinational ALU outputs
//   rsp_valid/rsp_ready    response handshake
//   rsp_data/rsp_carry     captured result and carry
//   rsp_id                 index of the served requester
//   busy                   high whenever the sequencer is not IDLE
module alu_sequencer #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_b0,
  input  logic [2:0] req_op0,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b1,
  input  logic [2:0] req_op1,
  output logic [7:0] reg_data,
  output logic       load_a,
  output logic       load_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_id,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  state_t     state_reg, state_next;
  logic       prio_reg;
  logic [7:0] a_reg, b_reg;
  logic [2:0] op_reg;
  logic       id_reg;
  logic [3:0] cnt_reg;
  logic [7:0] rsp_data_reg;
  logic       rsp_carry_reg;

  logic       grant_any;
  logic       grant_id;
  logic       handshake;
  logic       exec_done;

  // Grant: a lone requester wins outright; on contention the priority
  // pointer decides. A requester that drops req_valid before being granted
  // never reaches the handshake, so prio is untouched.
  always_comb begin
    grant_any = |req_valid;
    grant_id  = (req_valid == 2'b11) ? prio_reg : req_valid[1];
  end

  // req_ready is gated by reset so nothing is accepted while reset is held.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign req_ready[gi] = reset && (state_reg == IDLE) && grant_any &&
                           (grant_id == 1'(gi));
  end

  assign handshake = |(req_valid & req_ready);
  assign exec_done = (cnt_reg == EXEC_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake) state_next = LOAD_A;
      LOAD_A:  state_next = LOAD_B;
      LOAD_B:  state_next = EXEC;
      EXEC:    if (exec_done) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      prio_reg      <= 1'b0;
      a_reg         <= 8'h00;
      b_reg         <= 8'h00;
      op_reg        <= 3'd0;
      id_reg        <= 1'b0;
      cnt_reg       <= 4'd0;
      rsp_data_reg  <= 8'h00;
      rsp_carry_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (handshake) begin
        a_reg    <= grant_id ? req_a1  : req_a0;
        b_reg    <= grant_id ? req_b1  : req_b0;
        op_reg   <= grant_id ? req_op1 : req_op0;
        id_reg   <= grant_id;
        prio_reg <= ~grant_id;
      end
      if (state_reg == LOAD_B) begin
        cnt_reg <= 4'd0;
      end else if (state_reg == EXEC) begin
        cnt_reg <= cnt_reg + 4'd1;
      end
      if ((state_reg == EXEC) && exec_done) begin
        rsp_data_reg  <= alu_result;
        rsp_carry_reg <= alu_carry;
      end
    end
  end

  // Outputs are decoded from the state register, so they return to their
  // reset values one cycle after reset is sampled.
  always_comb begin
    reg_data = 8'h00;
    load_a   = 1'b0;
    load_b   = 1'b0;
    case (state_reg)
      LOAD_A: begin
        reg_data = a_reg;
        load_a   = 1'b1;
      end
      LOAD_B: begin
        reg_data = b_reg;
        load_b   = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_op    = (state_reg == IDLE) ? 3'd0 : op_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_carry = rsp_carry_reg;
  assign rsp_id    = id_reg;
  assign busy      = (state_reg != IDLE);

endmodule
